float_mantissa_multiplier: RTL
==============================

// Module: float_mantissa_multiplier
// PURPOSE
//  Iterative radix-2 shift-add multiplier for N-bit mantissas (hidden bit included).
//  Produces the raw 2N-bit product consumed directly by float_normalizer (its A input).
//  Sits in the FPU multiply path: operand unpack -> this block -> float_normalizer -> round.
//  One product per N+1 cycles; valid/ready handshake on both sides.
// PARAMETERS
//  N  24  mantissa width incl. hidden bit; product width is 2N
// PORTS
//  clock    in   1     system clock, all state updates on rising edge
//  reset_n  in   1     synchronous active-low reset
//  valid_i  in   1     operands a/b valid
//  ready_o  out  1     block can accept operands this cycle
//  a        in   N     multiplicand mantissa
//  b        in   N     multiplier mantissa
//  valid_o  out  1     product valid
//  ready_i  in   1     downstream (normalizer stage) accepts product
//  product  out  2N    unsigned a*b, exact, no truncation
// BEHAVIOUR
//  - One clock; reset is synchronous and active-low (reset_n sampled on clock rising edge).
//  - Reset: state=IDLE, valid_o=0, product=0, counter=0; ready_o forced 0 while reset_n=0.
//  - States IDLE, BUSY, DONE.
//  - IDLE: ready_o=1. valid_i&ready_o -> latch a (mcand), b (mplier lo half), hi half=0,
//    counter=0 -> BUSY.
//  - BUSY: ready_o=0, valid_o=0. Per cycle: if lo[0], {c,hi}=hi+mcand (N+1 bits);
//    then {c,hi,lo} >>= 1; counter++. After N iterations (counter==N-1 step) -> DONE.
//  - No early-out: zero operands take full latency.
//  - DONE: valid_o=1, product={hi,lo}, stable while ready_i=0.
//    ready_o=ready_i (back-to-back allowed).
//    ready_i & valid_i -> load new operands, go BUSY. ready_i & !valid_i -> IDLE.
//  - Latency: operands accepted at edge t -> valid_o high from edge t+N+1.
//  - a,b sampled only on accept; changes at other times are ignored.
//  - valid_o never drops without ready_i (AXI-style hold); product frozen meanwhile.
//  - Accumulator carry is kept in an N+1-bit add; the final product always fits 2N bits.
//  - Counter width $clog2(N+1); no wrap-around within an operation.
//  - reset_n low in any state (incl. mid-BUSY, or DONE with ready_i low): the result is
//    discarded, all reset values apply next edge, and IDLE resumes when reset_n goes high.
//  - Illegal state encodings return to IDLE.
// STRUCTURE
//  - State enum is module-local.
//  - Mantissa width constants (24 SP / 53 DP) are shared via fpu_pkg.
//  - No sub-module: the adder/shifter datapath is inline.
//  - float_normalizer is instantiated by the parent, fed from product when valid_o&ready_i.
// TESTING (N=4 unless noted)
//  1. reset, a=4'hF,b=4'hF, ready_i=1 -> valid_o exactly 5 cycles after accept,
//     product=8'hE1.
//  2. a=4'h0,b=4'h9 -> product=8'h00, same 5-cycle latency; a=4'h8,b=4'h1 -> 8'h08.
//  3. Backpressure: a=4'h8,b=4'h8, ready_i=0 for 3 cycles -> product=8'h40 held,
//     valid_o=1, ready_o=0; then ready_i=1 with valid_i a=3,b=5 -> 8'h40 accepted
//     same cycle, next product 8'h0F.
//  4. reset_n low 1 cycle mid-BUSY (iteration 2) -> valid_o=0, product=0;
//     next op a=7,b=6 -> 8'h2A.
//  5. Exhaustive 256 a/b pairs with random ready_i/valid_i gaps -> product==a*b.
//     No lost or duplicated results. Chained float_normalizer msb_pos/Y match the model.
//  6. N=24: a=24'hFFFFFF, b=24'hFFFFFF -> 48'hFFFFFE000001 after 25 cycles.

Source files
------------

// File: rtl/fpu_pkg.sv
// rtl/fpu_pkg.sv - shared FPU mantissa width constants
package fpu_pkg;
  localparam int MANT_SP = 24;
  localparam int MANT_DP = 53;
endpackage

// File: rtl/float_mantissa_multiplier.sv
// rtl/float_mantissa_multiplier.sv - iterative radix-2 shift-add mantissa multiplier
module float_mantissa_multiplier
  import fpu_pkg::*;
#(
  parameter int N = MANT_SP
) (
  input  logic           clock,
  input  logic           reset_n,
  input  logic           valid_i,
  output logic           ready_o,
  input  logic [N-1:0]   a,
  input  logic [N-1:0]   b,
  output logic           valid_o,
  input  logic           ready_i,
  output logic [2*N-1:0] product
);

  localparam int CW = $clog2(N + 1);
  localparam logic [CW-1:0] LAST = CW'(N);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [N-1:0]  mcand;
  logic [N-1:0]  hi;
  logic [N-1:0]  lo;
  logic [CW-1:0] count;
  logic [N:0]    sum;
  logic          accept;

  // Carry lands in sum[N] and becomes the new MSB of hi after the shift.
  always_comb begin
    sum = {1'b0, hi} + (lo[0] ? {1'b0, mcand} : '0);
  end

  always_comb begin
    state_nx = IDLE;
    ready_o  = 1'b0;
    valid_o  = 1'b0;
    case (state)
      IDLE: begin
        ready_o  = 1'b1;
        state_nx = valid_i ? BUSY : IDLE;
      end
      BUSY: begin
        state_nx = (count == LAST) ? DONE : BUSY;
      end
      DONE: begin
        valid_o = 1'b1;
        ready_o = ready_i;
        if (ready_i) begin
          state_nx = valid_i ? BUSY : IDLE;
        end else begin
          state_nx = DONE;
        end
      end
      default: state_nx = IDLE;
    endcase
    if (!reset_n) begin
      ready_o = 1'b0;
    end
  end

  assign accept  = valid_i & ready_o;
  assign product = {hi, lo};

  // N shift-add steps at count 0..N-1; the count==N cycle only hands off to DONE.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state <= IDLE;
      mcand <= '0;
      hi    <= '0;
      lo    <= '0;
      count <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        mcand <= a;
        hi    <= '0;
        lo    <= b;
        count <= '0;
      end else if (state == BUSY && count != LAST) begin
        hi    <= sum[N:1];
        lo    <= {sum[0], lo[N-1:1]};
        count <= count + CW'(1);
      end
    end
  end

endmodule
